// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one unified memory port between the instruction-fetch (IF) and
// data-memory (MEM) pipeline stages. One transaction is in flight at a time.
// A down-counter tracks the fixed memory latency. The response is steered back
// to whichever stage owns the transaction, and per-stage stall signals are
// produced for the pipeline hazard logic.
//
// Optional feature macro:
//   ARB_RR_EN  - defined  : round-robin on contention (grant the side that
//                           was not granted last).
//                undefined: fixed priority, MEM always wins contention.
//
// Parameters:
//   MEM_LAT  cycles from command issue to response (legal 1..15)
//   ADDR_W   address width
//   DATA_W   data width
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   IF_req, IF_addr           fetch request (held until IF_valid)
//   MEM_req, MEM_we,
//   MEM_addr, MEM_wdata       data request (held until MEM_valid)
//   mem_cmd                   to memory: 00 NONE, 01 LOAD, 10 STORE
//   mem_addr, mem_wdata       to memory, valid in the issue cycle
//   mem_rdata                 from memory, MEM_LAT cycles after issue
//   IF_rdata, IF_valid        fetch response
//   MEM_rdata, MEM_valid      load data / store acknowledge
//   AR_if_stall, AR_mem_stall per-stage hold requests
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LAT = 3,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IF_req,
    input  logic [ADDR_W-1:0] IF_addr,
    input  logic              MEM_req,
    input  logic              MEM_we,
    input  logic [ADDR_W-1:0] MEM_addr,
    input  logic [DATA_W-1:0] MEM_wdata,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] IF_rdata,
    output logic              IF_valid,
    output logic [DATA_W-1:0] MEM_rdata,
    output logic              MEM_valid,
    output logic              AR_if_stall,
    output logic              AR_mem_stall
);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_STORE = 2'b10;

    // Counter is loaded with MEM_LAT-1 at issue; reaching zero marks the
    // response cycle.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    owner_t     last_q,  last_d;
    logic [3:0] cnt_q,   cnt_d;

    logic       pick_mem;   // contention winner is MEM

    // ---------------------------------------------------------------------
    // Contention policy
    // ---------------------------------------------------------------------
`ifdef ARB_RR_EN
    assign pick_mem = (last_q == OWN_IF);
`else
    // Fixed priority: MEM (the older instruction) always wins. The last
    // pointer is still maintained but its value does not affect the result.
    assign pick_mem = (last_q == OWN_IF) || 1'b1;
`endif

    // ---------------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        mem_cmd   = CMD_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        IF_valid  = 1'b0;
        MEM_valid = 1'b0;

        // While reset is asserted every output stays at zero.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (MEM_req && (!IF_req || pick_mem)) begin
                        mem_cmd   = MEM_we ? CMD_STORE : CMD_LOAD;
                        mem_addr  = MEM_addr;
                        mem_wdata = MEM_we ? MEM_wdata : '0;
                        state_d   = BUSY;
                        owner_d   = OWN_MEM;
                        last_d    = OWN_MEM;
                        cnt_d     = CNT_INIT;
                    end else if (IF_req) begin
                        mem_cmd   = CMD_LOAD;
                        mem_addr  = IF_addr;
                        state_d   = BUSY;
                        owner_d   = OWN_IF;
                        last_d    = OWN_IF;
                        cnt_d     = CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        // Response cycle: no new grant here, back to IDLE
                        // so the next issue happens one cycle later.
                        IF_valid  = (owner_q == OWN_IF);
                        MEM_valid = (owner_q == OWN_MEM);
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Response data is passed straight through; consumers qualify it with
    // their valid.
    assign IF_rdata     = rst ? '0 : mem_rdata;
    assign MEM_rdata    = rst ? '0 : mem_rdata;
    assign AR_if_stall  = ~rst & IF_req  & ~IF_valid;
    assign AR_mem_stall = ~rst & MEM_req & ~MEM_valid;

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // An in-flight transaction is abandoned; its late response is
            // ignored because the FSM is back in IDLE.
            state_q <= IDLE;
            owner_q <= OWN_IF;
            last_q  <= OWN_IF;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A table of single-cycle vectors covers
// reset, a fetch, a store, and a request arriving in another transaction's
// response cycle. Hand-written sequences cover contention, reset in the middle
// of a transaction and MEM_LAT = 1 back-to-back fetches. A long randomized run
// is checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (MEM_LAT = 3)
    logic        rst;
    logic        IF_req;
    logic [63:0] IF_addr;
    logic        MEM_req;
    logic        MEM_we;
    logic [63:0] MEM_addr;
    logic [63:0] MEM_wdata;
    logic [1:0]  mem_cmd;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic [63:0] IF_rdata;
    logic        IF_valid;
    logic [63:0] MEM_rdata;
    logic        MEM_valid;
    logic        AR_if_stall;
    logic        AR_mem_stall;

    // Second DUT (MEM_LAT = 1)
    logic        l1_rst;
    logic        l1_if_req;
    logic [63:0] l1_if_addr;
    logic        l1_mem_req;
    logic        l1_mem_we;
    logic [63:0] l1_mem_addr;
    logic [63:0] l1_mem_wdata;
    logic [1:0]  l1_cmd;
    logic [63:0] l1_addr;
    logic [63:0] l1_wdata;
    logic [63:0] l1_if_rdata;
    logic        l1_if_valid;
    logic [63:0] l1_mem_rdata;
    logic        l1_mem_valid;
    logic        l1_if_stall;
    logic        l1_mem_stall;

    mem_arbiter #(.MEM_LAT(LAT), .ADDR_W(64), .DATA_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .IF_req       (IF_req),
        .IF_addr      (IF_addr),
        .MEM_req      (MEM_req),
        .MEM_we       (MEM_we),
        .MEM_addr     (MEM_addr),
        .MEM_wdata    (MEM_wdata),
        .mem_cmd      (mem_cmd),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .IF_rdata     (IF_rdata),
        .IF_valid     (IF_valid),
        .MEM_rdata    (MEM_rdata),
        .MEM_valid    (MEM_valid),
        .AR_if_stall  (AR_if_stall),
        .AR_mem_stall (AR_mem_stall)
    );

    mem_arbiter #(.MEM_LAT(1), .ADDR_W(64), .DATA_W(64)) dut_l1 (
        .clk          (clk),
        .rst          (l1_rst),
        .IF_req       (l1_if_req),
        .IF_addr      (l1_if_addr),
        .MEM_req      (l1_mem_req),
        .MEM_we       (l1_mem_we),
        .MEM_addr     (l1_mem_addr),
        .MEM_wdata    (l1_mem_wdata),
        .mem_cmd      (l1_cmd),
        .mem_addr     (l1_addr),
        .mem_wdata    (l1_wdata),
        .mem_rdata    (mem_rdata),
        .IF_rdata     (l1_if_rdata),
        .IF_valid     (l1_if_valid),
        .MEM_rdata    (l1_mem_rdata),
        .MEM_valid    (l1_mem_valid),
        .AR_if_stall  (l1_if_stall),
        .AR_mem_stall (l1_mem_stall)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: transaction level. A transaction issued at cycle t
    // responds at t+LAT; the arbiter is free again at t+LAT+1.
    // ------------------------------------------------------------------
    bit m_busy  = 1'b0;
    bit m_owner = 1'b0;   // 1 = MEM
    bit m_last  = 1'b0;   // 1 = MEM
    int m_issue = 0;

    task automatic model_step(input bit cmp);
        logic [1:0]  ecmd;
        logic [63:0] ea, ew;
        bit eifv, ememv, eifs, emems, grant, win_mem, resp;
        ecmd = 2'b00; ea = '0; ew = '0;
        eifv = 1'b0; ememv = 1'b0; grant = 1'b0; win_mem = 1'b0;
        resp = m_busy && (cyc - m_issue == LAT);
        if (!rst) begin
            if (m_busy) begin
                if (resp) begin
                    if (m_owner) ememv = 1'b1;
                    else         eifv  = 1'b1;
                end
            end else if (IF_req || MEM_req) begin
                grant = 1'b1;
`ifdef ARB_RR_EN
                win_mem = MEM_req && (!IF_req || !m_last);
`else
                win_mem = MEM_req;
`endif
                if (win_mem) begin
                    ecmd = MEM_we ? 2'b10 : 2'b01;
                    ea   = MEM_addr;
                    ew   = MEM_we ? MEM_wdata : 64'd0;
                end else begin
                    ecmd = 2'b01;
                    ea   = IF_addr;
                end
            end
        end
        eifs  = !rst && IF_req  && !eifv;
        emems = !rst && MEM_req && !ememv;
        if (cmp) begin
            chk("rnd.cmd", {62'd0, mem_cmd}, {62'd0, ecmd});
            if (ecmd != 2'b00 || rst) begin
                chk("rnd.addr",  mem_addr,  ea);
                chk("rnd.wdata", mem_wdata, ew);
            end
            chk("rnd.if_valid",  {63'd0, IF_valid},     {63'd0, eifv});
            chk("rnd.mem_valid", {63'd0, MEM_valid},    {63'd0, ememv});
            chk("rnd.if_stall",  {63'd0, AR_if_stall},  {63'd0, eifs});
            chk("rnd.mem_stall", {63'd0, AR_mem_stall}, {63'd0, emems});
            if (eifv)  chk("rnd.if_rdata",  IF_rdata,  mem_rdata);
            if (ememv) chk("rnd.mem_rdata", MEM_rdata, mem_rdata);
        end
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b0;
        end else if (resp) begin
            m_busy = 1'b0;
        end else if (grant) begin
            m_busy  = 1'b1;
            m_owner = win_mem;
            m_issue = cyc;
            m_last  = win_mem;
        end
        cyc++;
    endtask

    // Close out the current cycle: update the model, move to just after the
    // next rising edge and present fresh memory read data.
    task automatic finish_cycle(input bit cmp);
        model_step(cmp);
        @(posedge clk);
        #1;
        mem_rdata = {$urandom, $urandom};
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        r;
        logic        ifq;
        logic [63:0] ifa;
        logic        mq;
        logic        mw;
        logic [63:0] ma;
        logic [63:0] mwd;
        logic [1:0]  e_cmd;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic        e_ifv;
        logic        e_memv;
        logic        e_ifs;
        logic        e_mems;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic ifq, input logic [63:0] ifa,
        input logic mq, input logic mw, input logic [63:0] ma, input logic [63:0] mwd,
        input logic [1:0] c, input logic [63:0] ea, input logic [63:0] ew,
        input logic ifv, input logic memv, input logic ifs, input logic mems);
        vec_t v;
        v.r = r; v.ifq = ifq; v.ifa = ifa; v.mq = mq; v.mw = mw; v.ma = ma; v.mwd = mwd;
        v.e_cmd = c; v.e_addr = ea; v.e_wdata = ew;
        v.e_ifv = ifv; v.e_memv = memv; v.e_ifs = ifs; v.e_mems = mems;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        rst = v.r; IF_req = v.ifq; IF_addr = v.ifa;
        MEM_req = v.mq; MEM_we = v.mw; MEM_addr = v.ma; MEM_wdata = v.mwd;
        @(negedge clk);
        chk({tag, ".cmd"}, {62'd0, mem_cmd}, {62'd0, v.e_cmd});
        if (v.e_cmd != 2'b00 || v.r) begin
            chk({tag, ".addr"},  mem_addr,  v.e_addr);
            chk({tag, ".wdata"}, mem_wdata, v.e_wdata);
        end
        chk({tag, ".if_valid"},  {63'd0, IF_valid},     {63'd0, v.e_ifv});
        chk({tag, ".mem_valid"}, {63'd0, MEM_valid},    {63'd0, v.e_memv});
        chk({tag, ".if_stall"},  {63'd0, AR_if_stall},  {63'd0, v.e_ifs});
        chk({tag, ".mem_stall"}, {63'd0, AR_mem_stall}, {63'd0, v.e_mems});
        if (v.e_ifv || v.r)  chk({tag, ".if_rdata"},  IF_rdata,  v.r ? 64'd0 : mem_rdata);
        if (v.e_memv || v.r) chk({tag, ".mem_rdata"}, MEM_rdata, v.r ? 64'd0 : mem_rdata);
        $display("vec %s cmd=%0d addr=%0h if_v=%0d mem_v=%0d", tag, mem_cmd, mem_addr, IF_valid, MEM_valid);
        finish_cycle(1'b0);
    endtask

    vec_t tbl[22];
    vec_t v;

    initial begin
        rst = 1'b1; IF_req = 1'b0; IF_addr = '0; MEM_req = 1'b0; MEM_we = 1'b0;
        MEM_addr = '0; MEM_wdata = '0; mem_rdata = '0;
        l1_rst = 1'b1; l1_if_req = 1'b0; l1_if_addr = '0; l1_mem_req = 1'b0;
        l1_mem_we = 1'b0; l1_mem_addr = '0; l1_mem_wdata = '0;

        //              rst ifq ifa        mq we ma         mwd            cmd addr       wdata          ifv memv ifs mems
        tbl[0]  = mk(1, 1, 64'h1000, 1, 1, 64'h2000, 64'h55,         2'b00, 64'h0,    64'h0,         0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 64'h1000, 1, 1, 64'h2000, 64'h55,         2'b00, 64'h0,    64'h0,         0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 64'h0,    0, 0, 64'h0,    64'h0,          2'b00, 64'h0,    64'h0,         0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 64'h1000, 0, 0, 64'h0,    64'h0,          2'b01, 64'h1000, 64'h0,         0, 0, 1, 0);
        tbl[4]  = mk(0, 1, 64'h1000, 0, 0, 64'h0,    64'h0,          2'b00, 64'h0,    64'h0,         0, 0, 1, 0);
        tbl[5]  = mk(0, 1, 64'h1000, 0, 0, 64'h0,    64'h0,          2'b00, 64'h0,    64'h0,         0, 0, 1, 0);
        tbl[6]  = mk(0, 1, 64'h1000, 0, 0, 64'h0,    64'h0,          2'b00, 64'h0,    64'h0,         1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 64'h0,    0, 0, 64'h0,    64'h0,          2'b00, 64'h0,    64'h0,         0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 64'h0,    1, 1, 64'h2000, 64'hDEADBEEF,   2'b10, 64'h2000, 64'hDEADBEEF,  0, 0, 0, 1);
        tbl[9]  = mk(0, 0, 64'h0,    1, 1, 64'h2000, 64'hDEADBEEF,   2'b00, 64'h0,    64'h0,         0, 0, 0, 1);
        tbl[10] = mk(0, 0, 64'h0,    1, 1, 64'h2000, 64'hDEADBEEF,   2'b00, 64'h0,    64'h0,         0, 0, 0, 1);
        tbl[11] = mk(0, 0, 64'h0,    1, 1, 64'h2000, 64'hDEADBEEF,   2'b00, 64'h0,    64'h0,         0, 1, 0, 0);
        tbl[12] = mk(0, 0, 64'h0,    0, 0, 64'h0,    64'h0,          2'b00, 64'h0,    64'h0,         0, 0, 0, 0);
        tbl[13] = mk(0, 1, 64'h1004, 0, 0, 64'h0,    64'h0,          2'b01, 64'h1004, 64'h0,         0, 0, 1, 0);
        // address changes while busy have no effect
        tbl[14] = mk(0, 1, 64'hBAD0, 0, 0, 64'h0,    64'h0,          2'b00, 64'h0,    64'h0,         0, 0, 1, 0);
        tbl[15] = mk(0, 1, 64'h1004, 0, 0, 64'h0,    64'h0,          2'b00, 64'h0,    64'h0,         0, 0, 1, 0);
        // MEM request arrives in IF's response cycle: stalled, granted next
        tbl[16] = mk(0, 1, 64'h1004, 1, 0, 64'h3000, 64'h1234,       2'b00, 64'h0,    64'h0,         1, 0, 0, 1);
        // load drives wdata as zero even though MEM_wdata is non-zero
        tbl[17] = mk(0, 0, 64'h0,    1, 0, 64'h3000, 64'h1234,       2'b01, 64'h3000, 64'h0,         0, 0, 0, 1);
        tbl[18] = mk(0, 0, 64'h0,    1, 0, 64'h3000, 64'h1234,       2'b00, 64'h0,    64'h0,         0, 0, 0, 1);
        tbl[19] = mk(0, 0, 64'h0,    1, 0, 64'h3000, 64'h1234,       2'b00, 64'h0,    64'h0,         0, 0, 0, 1);
        tbl[20] = mk(0, 0, 64'h0,    1, 0, 64'h3000, 64'h1234,       2'b00, 64'h0,    64'h0,         0, 1, 0, 0);
        tbl[21] = mk(0, 0, 64'h0,    0, 0, 64'h0,    64'h0,          2'b00, 64'h0,    64'h0,         0, 0, 0, 0);

        @(posedge clk);
        #1;
        mem_rdata = {$urandom, $urandom};

        for (int i = 0; i < 22; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // ---------------- contention, both held ----------------
        run_vec(mk(1, 0, 64'h0, 0, 0, 64'h0, 64'h0, 2'b00, 64'h0, 64'h0, 0, 0, 0, 0), "cont.rst");
        for (int c = 0; c < 12; c++) begin
            logic [63:0] exp_a;
            logic        exp_ifv, exp_memv, issue;
            issue    = (c % 4 == 0);
`ifdef ARB_RR_EN
            exp_a    = (c == 4) ? 64'hA000 : 64'hB000;
            exp_ifv  = (c == 7);
            exp_memv = (c == 3) || (c == 11);
`else
            exp_a    = 64'hB000;
            exp_ifv  = 1'b0;
            exp_memv = (c % 4 == 3);
`endif
            v = mk(0, 1, 64'hA000, 1, 0, 64'hB000, 64'h0,
                   issue ? 2'b01 : 2'b00, exp_a, 64'h0,
                   exp_ifv, exp_memv, !exp_ifv, !exp_memv);
            run_vec(v, $sformatf("cont%0d", c));
        end

        // ---------------- reset mid-transaction ----------------
        run_vec(mk(1, 0, 64'h0, 0, 0, 64'h0,    64'h0, 2'b00, 64'h0,    64'h0, 0, 0, 0, 0), "rmid.pre");
        run_vec(mk(0, 0, 64'h0, 1, 0, 64'h4000, 64'h0, 2'b01, 64'h4000, 64'h0, 0, 0, 0, 1), "rmid0");
        run_vec(mk(1, 0, 64'h0, 1, 0, 64'h4000, 64'h0, 2'b00, 64'h0,    64'h0, 0, 0, 0, 0), "rmid1");
        for (int c = 2; c < 5; c++)
            run_vec(mk(0, 0, 64'h0, 0, 0, 64'h0, 64'h0, 2'b00, 64'h0, 64'h0, 0, 0, 0, 0), $sformatf("rmid%0d", c));
        run_vec(mk(0, 0, 64'h0, 1, 0, 64'h5000, 64'h0, 2'b01, 64'h5000, 64'h0, 0, 0, 0, 1), "rmid5");
        run_vec(mk(0, 0, 64'h0, 1, 0, 64'h5000, 64'h0, 2'b00, 64'h0,    64'h0, 0, 0, 0, 1), "rmid6");
        run_vec(mk(0, 0, 64'h0, 1, 0, 64'h5000, 64'h0, 2'b00, 64'h0,    64'h0, 0, 0, 0, 1), "rmid7");
        run_vec(mk(0, 0, 64'h0, 1, 0, 64'h5000, 64'h0, 2'b00, 64'h0,    64'h0, 0, 1, 0, 0), "rmid8");
        run_vec(mk(0, 0, 64'h0, 0, 0, 64'h0,    64'h0, 2'b00, 64'h0,    64'h0, 0, 0, 0, 0), "rmid9");

        // ---------------- randomized run against the model ----------------
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            IF_req    = ($urandom_range(0, 9) < 6);
            MEM_req   = ($urandom_range(0, 9) < 5);
            MEM_we    = $urandom_range(0, 1) == 1;
            IF_addr   = {$urandom, $urandom};
            MEM_addr  = {$urandom, $urandom};
            MEM_wdata = {$urandom, $urandom};
            @(negedge clk);
            finish_cycle(1'b1);
        end

        // ---------------- MEM_LAT = 1 back-to-back fetches ----------------
        rst = 1'b0; IF_req = 1'b0; MEM_req = 1'b0;
        l1_rst = 1'b0; l1_if_req = 1'b1; l1_if_addr = 64'h8000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("lat1.%0d.cmd", c),      {62'd0, l1_cmd},      (c % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("lat1.%0d.if_valid", c), {63'd0, l1_if_valid}, (c % 2 == 1) ? 64'd1 : 64'd0);
            chk($sformatf("lat1.%0d.stall", c),    {63'd0, l1_if_stall}, (c % 2 == 0) ? 64'd1 : 64'd0);
            if (c % 2 == 0) chk($sformatf("lat1.%0d.addr", c), l1_addr, 64'h8000);
            if (c % 2 == 1) chk($sformatf("lat1.%0d.rdata", c), l1_if_rdata, mem_rdata);
            $display("lat1 cyc %0d cmd=%0d if_v=%0d", c, l1_cmd, l1_if_valid);
            finish_cycle(1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
